// File: rtl/ones_gen_pkg.sv
// Shared types and constants for the ones-count pattern generator.
// Holds the FSM encoding, the LFSR feedback taps and the default seed.
package ones_gen_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LfsrTaps    = 16'hB400;
    localparam logic [15:0] DefaultSeed = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] shifted;
        shifted = {1'b0, s[15:1]};
        return s[0] ? (shifted ^ LfsrTaps) : shifted;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that advances one step per enabled cycle.
// Asynchronous reset loads the seed.
module lfsr16
    import ones_gen_pkg::*;
#(
    parameter logic [15:0] SEED = DefaultSeed
) (
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (en_i) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/ones_pattern_gen.sv
// Builds a WIDTH-bit word holding exactly the requested number of ones, scanning one
// bit position per cycle and letting an LFSR pick which positions get set.
module ones_pattern_gen
    import ones_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1,
    parameter logic [15:0] SEED  = DefaultSeed
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             data_val_i,
    input  logic [CNT_W-1:0] data_i,
    output logic             ready_o,
    output logic             data_val_o,
    output logic [WIDTH-1:0] data_o
);

    localparam logic [CNT_W-1:0] WidthC  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] LastPtr = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             val_q, val_d;

    logic [15:0]      lfsr_state;
    logic             lfsr_bit;
    logic             scan_en;
    logic             set_bit;
    logic [CNT_W-1:0] req_sat;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] word_next;

    assign scan_en = (state_q == StScan);

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .en_i    (scan_en),
        .state_o (lfsr_state)
    );

    // Only the LSB steers the decision; the rest of the state just feeds the sequence.
    assign lfsr_bit = ^(lfsr_state & 16'h0001);

    assign req_sat = (data_i > WidthC) ? WidthC : data_i;

    // Forced set when the remaining ones exactly fill the remaining positions.
    assign set_bit   = (rem_q != '0) && ((rem_q == (WidthC - ptr_q)) || lfsr_bit);
    assign bit_mask  = WIDTH'(1) << ptr_q;
    assign word_next = set_bit ? (work_q | bit_mask) : work_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        work_d  = work_q;
        data_d  = data_q;
        val_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (data_val_i) begin
                    rem_d   = req_sat;
                    ptr_d   = '0;
                    work_d  = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                work_d = word_next;
                ptr_d  = ptr_q + CNT_W'(1);
                if (set_bit) begin
                    rem_d = rem_q - CNT_W'(1);
                end
                if (ptr_q == LastPtr) begin
                    data_d  = word_next;
                    val_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            rem_q   <= '0;
            work_q  <= '0;
            data_q  <= '0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            work_q  <= work_d;
            data_q  <= data_d;
            val_q   <= val_d;
        end
    end

    assign ready_o    = (state_q == StIdle);
    assign data_val_o = val_q;
    assign data_o     = data_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Self-checking bench for ones_pattern_gen with a behavioural word-generation model.
module tb_ones_pattern_gen;

    localparam int          WIDTH = 8;
    localparam int          CNT_W = 4;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic             clk = 1'b0;
    logic             srst = 1'b1;
    logic             data_val_i = 1'b0;
    logic [CNT_W-1:0] data_i = '0;
    logic             ready_o;
    logic             data_val_o;
    logic [WIDTH-1:0] data_o;

    int total = 0;
    int bad   = 0;

    logic [15:0] mdl_lfsr;
    int          golden_cnt[3] = '{3, 5, 1};
    logic [7:0]  golden_word[3];

    ones_pattern_gen #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .SEED  (SEED)
    ) dut (
        .clk_i      (clk),
        .srst_i     (srst),
        .data_val_i (data_val_i),
        .data_i     (data_i),
        .ready_o    (ready_o),
        .data_val_o (data_val_o),
        .data_o     (data_o)
    );

    always #5 clk = ~clk;

    // Place min(cnt,WIDTH) ones left-to-right: forced when the rest must all be ones,
    // otherwise taken when the LFSR LSB is set; the LFSR steps once per position.
    task automatic model_gen(input int cnt, output logic [7:0] w);
        int r;
        r = (cnt > WIDTH) ? WIDTH : cnt;
        w = '0;
        for (int p = 0; p < WIDTH; p++) begin
            if (r > 0 && (r == WIDTH - p || mdl_lfsr[0])) begin
                w[p] = 1'b1;
                r--;
            end
            mdl_lfsr = {1'b0, mdl_lfsr[15:1]} ^ (mdl_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    endtask

    // Issue one request when idle; report first pulse offset, its word, pulse count and
    // the offset at which ready is seen again (offset n = value sampled at edge k+n).
    task automatic run_req(input int cnt, output logic [7:0] word, output int lat,
                           output int rdy_at, output int pulses);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        data_i     = cnt[CNT_W-1:0];
        data_val_i = 1'b1;
        @(posedge clk);
        #1;
        data_val_i = 1'b0;
        data_i     = 4'($urandom);
        word   = '0;
        lat    = 0;
        rdy_at = 0;
        pulses = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (data_val_o) begin
                pulses++;
                if (lat == 0) begin
                    lat  = n;
                    word = data_o;
                end
            end
            if (ready_o) begin
                rdy_at = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        srst       = 1'b1;
        data_val_i = 1'b0;
        data_i     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", ready_o); end
        total++; if (data_val_o !== 1'b0) begin bad++; $display("FAIL rst_val got=%b want=0", data_val_o); end
        total++; if (data_o !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", data_o); end
        srst     = 1'b0;
        mdl_lfsr = SEED;
        @(negedge clk);
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", ready_o); end
        total++; if (data_val_o !== 1'b0) begin bad++; $display("FAIL post_rst_val got=%b want=0", data_val_o); end
    endtask

    task automatic test_golden();
        logic [7:0] exp, word;
        int lat, rdy, pul;
        for (int i = 0; i < 3; i++) begin
            model_gen(golden_cnt[i], exp);
            run_req(golden_cnt[i], word, lat, rdy, pul);
            golden_word[i] = word;
            total++; if (word !== exp) begin bad++; $display("FAIL golden_word[%0d] got=%h want=%h", i, word, exp); end
            total++; if (lat != 9) begin bad++; $display("FAIL golden_lat[%0d] got=%0d want=9", i, lat); end
        end
    endtask

    task automatic test_zero_full();
        int cnts[3] = '{0, 8, 15};
        logic [7:0] exp, word, fixed;
        int lat, rdy, pul;
        for (int i = 0; i < 3; i++) begin
            model_gen(cnts[i], exp);
            run_req(cnts[i], word, lat, rdy, pul);
            fixed = (cnts[i] == 0) ? 8'h00 : 8'hFF;
            total++; if (word !== fixed) begin bad++; $display("FAIL edge_word cnt=%0d got=%h want=%h", cnts[i], word, fixed); end
            total++; if (word !== exp) begin bad++; $display("FAIL edge_model cnt=%0d got=%h want=%h", cnts[i], word, exp); end
            total++; if (lat != 9) begin bad++; $display("FAIL edge_lat cnt=%0d got=%0d want=9", cnts[i], lat); end
            total++; if (rdy != 10) begin bad++; $display("FAIL edge_ready cnt=%0d got=%0d want=10", cnts[i], rdy); end
            total++; if (pul != 1) begin bad++; $display("FAIL edge_pulses cnt=%0d got=%0d want=1", cnts[i], pul); end
        end
    endtask

    task automatic test_popcount();
        logic [7:0] exp, word;
        logic [7:0] first[8];
        bit         differs[8];
        int lat, rdy, pul, c;
        for (int k = 0; k < 8; k++) differs[k] = 1'b0;
        for (int cc = 1; cc <= 7; cc++) begin
            for (int rep = 0; rep < 50; rep++) begin
                model_gen(cc, exp);
                run_req(cc, word, lat, rdy, pul);
                if (rep == 0) first[cc] = word;
                else if (word !== first[cc]) differs[cc] = 1'b1;
                total++; if (word !== exp) begin bad++; $display("FAIL pop_word cnt=%0d got=%h want=%h", cc, word, exp); end
                total++; if ($countones(word) != cc) begin bad++; $display("FAIL pop_count got=%0d want=%0d", $countones(word), cc); end
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            total++; if (!differs[cc]) begin bad++; $display("FAIL pop_variety cnt=%0d got=constant want=varied", cc); end
        end
        for (int i = 0; i < 20; i++) begin
            c = $urandom_range(0, 15);
            model_gen(c, exp);
            run_req(c, word, lat, rdy, pul);
            total++; if (word !== exp) begin bad++; $display("FAIL rand_word cnt=%0d got=%h want=%h", c, word, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] req[50];
        int         at[5];
        logic [7:0] got[5];
        logic [7:0] exp;
        int np, guard;
        np = 0;
        guard = 0;
        for (int i = 0; i < 50; i++) req[i] = 4'($urandom_range(0, 15));
        @(negedge clk);
        while (!ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 62; i++) begin
            if (i > 0) @(negedge clk);
            if (i > 0 && data_val_o) begin
                if (np < 5) begin
                    at[np]  = i;
                    got[np] = data_o;
                end
                np++;
            end
            if (i < 50) begin
                data_val_i = 1'b1;
                data_i     = req[i];
            end else begin
                data_val_i = 1'b0;
            end
        end
        total++; if (np != 5) begin bad++; $display("FAIL b2b_pulses got=%0d want=5", np); end
        for (int j = 0; j < 5 && j < np; j++) begin
            model_gen(int'(req[10 * j]), exp);
            total++; if (at[j] != 10 * j + 9) begin bad++; $display("FAIL b2b_time[%0d] got=%0d want=%0d", j, at[j], 10 * j + 9); end
            total++; if (got[j] !== exp) begin bad++; $display("FAIL b2b_word[%0d] got=%h want=%h", j, got[j], exp); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp, word;
        int lat, rdy, pul, np;
        model_gen(4, exp);
        run_req(4, word, lat, rdy, pul);
        @(negedge clk);
        data_i     = 4'd5;
        data_val_i = 1'b1;
        @(posedge clk);
        #1;
        data_val_i = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        srst = 1'b1;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b want=1", ready_o); end
        total++; if (data_val_o !== 1'b0) begin bad++; $display("FAIL mid_rst_val got=%b want=0", data_val_o); end
        total++; if (data_o !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%h want=00", data_o); end
        @(negedge clk);
        srst     = 1'b0;
        mdl_lfsr = SEED;
        np = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (data_val_o) np++;
        end
        total++; if (np != 0) begin bad++; $display("FAIL mid_rst_pulses got=%0d want=0", np); end
        for (int i = 0; i < 3; i++) begin
            model_gen(golden_cnt[i], exp);
            run_req(golden_cnt[i], word, lat, rdy, pul);
            total++; if (word !== golden_word[i]) begin bad++; $display("FAIL replay_word[%0d] got=%h want=%h", i, word, golden_word[i]); end
            total++; if (word !== exp) begin bad++; $display("FAIL replay_model[%0d] got=%h want=%h", i, word, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_zero_full();
        test_popcount();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
